// File: rtl/meter_countdown.sv
`timescale 1ns/1ps
// meter_countdown
//   Time-keeping end of the parking-meter datapath. Adopts the meter value
//   on load, decrements it once per second, and derives the display flash
//   control and a 4-digit BCD image. The BCD image is produced by a
//   double-dabble converter that does one shift per cycle.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   valin      meter value from the coin/reset counter
//   load       one-cycle pulse: adopt valin (saturated to MAX_VAL)
//   val        remaining time, fed back to the counter
//   bcd        val as BCD, [15:12] thousands .. [3:0] units
//   bcd_valid  one-cycle pulse when bcd is updated
//   low_time   1 when 0 < val < LOW_THRESH
//   expired    1 when val == 0
//   blank      1 = display dark for this phase
//
// Conversion FSM
//   state | meaning
//   IDLE  | bcd matches last_conv; wait for val to differ
//   SHIFT | 14 add-3/shift iterations on the captured value
//   DONE  | publish scratch to bcd, pulse bcd_valid
module meter_countdown #(
    parameter int TICK_DIV   = 100000000,
    parameter int LOW_THRESH = 200,
    parameter int MAX_VAL    = 9999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] valin,
    input  logic        load,
    output logic [13:0] val,
    output logic [15:0] bcd,
    output logic        bcd_valid,
    output logic        low_time,
    output logic        expired,
    output logic        blank
);

    localparam int            CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(TICK_DIV / 2 - 1);
    localparam logic [13:0]   MAX_V    = 14'(MAX_VAL);
    localparam logic [13:0]   LOW_V    = 14'(LOW_THRESH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // ------------------------------------------------------------------
    // Free-running prescaler
    // ------------------------------------------------------------------
    logic [CW-1:0] cnt;
    logic          sec_tick;
    logic          half_tick;

    assign sec_tick  = (cnt == CNT_LAST);
    assign half_tick = sec_tick || (cnt == CNT_HALF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (sec_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Remaining-time register
    // ------------------------------------------------------------------
    logic [13:0] val_next;

    always_comb begin
        val_next = val;
        if (load) begin
            val_next = (valin > MAX_V) ? MAX_V : valin;
        end else if (sec_tick && (val != 14'd0)) begin
            val_next = val - 14'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val <= 14'd0;
        end else begin
            val <= val_next;
        end
    end

    assign expired  = (val == 14'd0);
    assign low_time = (val != 14'd0) && (val < LOW_V);

    // ------------------------------------------------------------------
    // Flash control. Looking at val_next lets blank restart at 0 on the
    // same edge that val moves into a different display mode.
    // ------------------------------------------------------------------
    logic expired_next;
    logic low_next;
    logic mode_change;

    assign expired_next = (val_next == 14'd0);
    assign low_next     = (val_next != 14'd0) && (val_next < LOW_V);
    assign mode_change  = (expired_next != expired) || (low_next != low_time);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank <= 1'b0;
        end else if (mode_change) begin
            blank <= 1'b0;
        end else if (expired) begin
            if (half_tick) begin
                blank <= ~blank;
            end
        end else if (low_time) begin
            if (sec_tick) begin
                blank <= ~blank;
            end
        end else begin
            blank <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Double-dabble converter
    // ------------------------------------------------------------------
    conv_state_t state;
    logic [13:0] shreg;
    logic [13:0] cap;
    logic [13:0] last_conv;
    logic [15:0] scratch;
    logic [15:0] adj;
    logic [3:0]  iter;

    always_comb begin
        adj = scratch;
        for (int d = 0; d < 4; d++) begin
            if (scratch[d*4 +: 4] >= 4'd5) begin
                adj[d*4 +: 4] = scratch[d*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shreg     <= 14'd0;
            cap       <= 14'd0;
            last_conv <= 14'd0;
            scratch   <= 16'd0;
            iter      <= 4'd0;
            bcd       <= 16'd0;
            bcd_valid <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (val != last_conv) begin
                        cap     <= val;
                        shreg   <= val;
                        scratch <= 16'd0;
                        iter    <= 4'd0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // A newer val makes the running conversion stale.
                    if (val != cap) begin
                        cap     <= val;
                        shreg   <= val;
                        scratch <= 16'd0;
                        iter    <= 4'd0;
                    end else begin
                        scratch <= (adj << 1) | 16'(shreg[13]);
                        shreg   <= shreg << 1;
                        if (iter == 4'd13) begin
                            state <= DONE;
                        end else begin
                            iter <= iter + 4'd1;
                        end
                    end
                end
                DONE: begin
                    // val moved on the last shift edge: never publish it.
                    if (val != cap) begin
                        cap     <= val;
                        shreg   <= val;
                        scratch <= 16'd0;
                        iter    <= 4'd0;
                        state   <= SHIFT;
                    end else begin
                        bcd       <= scratch;
                        bcd_valid <= 1'b1;
                        last_conv <= cap;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/meter_countdown.md
Name: meter_countdown

Overview:
- Time-keeping end of the parking-meter datapath.
- Takes the meter value from the coin/reset counter when told to, decrements it once per second, and returns the decremented value to the counter.
- Also derives the display blanking (flash) controls and a sequentially converted 4-digit BCD image for the seven-segment driver.

Parameters:
TICK_DIV, 100000000, clk cycles per second (1 s at 100 MHz); must be even and >= 4
LOW_THRESH, 200, remaining values 1..LOW_THRESH-1 are "low time"
MAX_VAL, 9999, saturation ceiling for loaded values

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
valin  input  14  meter value from counter (already saturated upstream)
load  input  1  one-cycle pulse: adopt valin as remaining time
val  output  14  remaining time, fed back to counter
bcd  output  16  val as 4 BCD digits, [15:12] thousands .. [3:0] units
bcd_valid  output  1  one-cycle pulse when bcd is updated
low_time  output  1  1 when 0 < val < LOW_THRESH
expired  output  1  1 when val == 0
blank  output  1  1 = display dark for this phase

Behaviour:
Reset:
- Asynchronous, on rst_n low; takes effect immediately, including mid-conversion.
- Reset state: val=0, bcd=0, bcd_valid=0, blank=0, prescaler=0, conversion FSM=IDLE.
- low_time and expired are combinational from val, so expired=1 and low_time=0 out of reset.

Prescaler:
- Counts 0..TICK_DIV-1, then wraps.
- half_tick asserts for one cycle at count TICK_DIV/2-1 and at count TICK_DIV-1.
- sec_tick asserts for one cycle at count TICK_DIV-1 only.
- Free-running: never restarted by load.

Remaining register:
- load=1: val <= min(valin, MAX_VAL) on the next edge.
- Otherwise, sec_tick=1 and val>0: val <= val-1.
- val==0: holds at 0. No underflow.
- load and sec_tick in the same cycle: load wins; that tick's decrement is dropped.

Flash (blank):
- expired: blank toggles on every half_tick, giving 0.5 s on / 0.5 s off.
- low_time: blank toggles on every sec_tick, giving 1 s on / 1 s off.
- Otherwise: blank=0, forced on the next edge.
- When val enters expired or low_time, blank starts from 0, i.e. display on first.

BCD conversion FSM (double-dabble, one shift per cycle):
- IDLE: on any change of val (load or decrement, detected as val != last_converted), capture val into a shift register and clear scratch BCD; go to SHIFT.
- SHIFT: 14 iterations. Each iteration adds 3 to every scratch digit >= 5, then shifts left 1. After the 14th iteration go to DONE.
- DONE: bcd <= scratch, bcd_valid=1 for this cycle, last_converted <= captured value; go to IDLE.
- Latency: bcd_valid occurs 16 cycles after the edge where val changed.
- val changes again while in SHIFT: abort, recapture the new val, restart at iteration 0. Latest value wins; the stale result is never presented.
- bcd holds its last result between conversions; no bcd_valid without a change.
- A load of the same value as current val causes no conversion.

Width/arithmetic:
- All values unsigned 14-bit.
- Every BCD digit output is <= 9.

Test Plan:
1. Reset, then check the initial state. Bench uses TICK_DIV=10.
   - Stimulus: rst_n low 3 cycles, release.
   - Required: val=0, expired=1, bcd=0x0000, no bcd_valid; blank toggles every 5 cycles.
2. Load and decrement.
   - Stimulus: load with valin=205.
   - Required: bcd=0x0205 with bcd_valid 16 cycles later; each sec_tick steps val 205->204->203; bcd_valid follows each step; low_time=0 until val=199, then 1.
3. Low-time and expiry flash.
   - Stimulus: load 2.
   - Required: low_time=1, blank toggling every 10 cycles. At val=0: expired=1, low_time=0, blank toggling every 5 cycles, val stays 0 through 3 further ticks.
4. Collision and saturation.
   - Stimulus: load 150 asserted on the same cycle as sec_tick.
   - Required: val=150, not 149.
   - Stimulus: load valin=12000.
   - Required: val=9999, bcd=0x9999.
5. Mid-conversion abort.
   - Stimulus: load 1234, then load 56 four cycles later.
   - Required: exactly one bcd_valid, with bcd=0x0056 16 cycles after the second load; 0x1234 never appears.
6. Async reset mid-operation.
   - Stimulus: drop rst_n between edges during SHIFT with val=500.
   - Required: val, bcd and blank clear immediately without waiting for an edge; bcd_valid stays 0.
